// File: rtl/q31_pkg.sv
// q31_pkg: shared state encoding and default widths for the q31 arbiter blocks
package q31_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/q31_rr_pick.sv
// q31_rr_pick: combinational circular priority search starting at ptr
// Ports: req (request vector), ptr (highest-priority index),
//        sel (first requesting index at or after ptr, wrapping), any_req (some request set)
module q31_rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any_req
);
  // Scan offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[PW'((int'(ptr) + k) % N)]) sel = PW'((int'(ptr) + k) % N);
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/q31_shared_reg_arbiter.sv
// q31_shared_reg_arbiter: round-robin arbiter sharing one W-bit register among N requesters
// Ports: clk, rstn (async active-low), req/din (per-requester request and data slice),
//        gnt (one-hot grant), ack (write-complete pulse), owner (last granted index),
//        busy (transaction in flight), A (shared register)
module q31_shared_reg_arbiter
  import q31_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  localparam int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    gnt,
  output logic            ack,
  output logic [PW-1:0]   owner,
  output logic            busy,
  output logic [W-1:0]    A
);
  state_t        state_q;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, sel;
  logic [N-1:0]  gnt_q;
  logic          ack_q, busy_q, any_req;
  logic [W-1:0]  a_q;
  q31_rr_pick #(.N(N)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .sel(sel),
    .any_req(any_req)
  );
  assign ptr_d = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any_req) begin
          state_q <= ST_GRANT;
          gnt_q   <= N'(1) << sel;
          owner_q <= sel;
          busy_q  <= 1'b1;
        end
        ST_GRANT: begin
          gnt_q <= '0;
          // A dropped request aborts without touching ptr, so that requester keeps priority.
          if (req[owner_q]) begin
            a_q     <= din[owner_q*W +: W];
            ack_q   <= 1'b1;
            ptr_q   <= ptr_d;
            state_q <= ST_DONE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign A     = a_q;
endmodule

// File: tb/tb_q31_shared_reg_arbiter.sv
// tb_q31_shared_reg_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_q31_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int PW = 2;
  typedef struct {
    int           who;
    logic [W-1:0] data;
  } ack_t;
  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   gnt;
  logic           ack, busy;
  logic [PW-1:0]  owner;
  logic [W-1:0]   A;
  int             errors = 0;
  int             checks = 0;
  int             mptr = 0;
  logic [W-1:0]   ma = '0;
  int             exp_gnt[$];
  ack_t           exp_ack[$];
  int             mon_w;
  ack_t           mon_e;
  always #5 clk = ~clk;
  q31_shared_reg_arbiter #(.N(N), .W(W)) dut (
    .clk(clk),
    .rstn(rstn),
    .req(req),
    .din(din),
    .gnt(gnt),
    .ack(ack),
    .owner(owner),
    .busy(busy),
    .A(A)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference arbitration: first requester found walking circularly from the model pointer.
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction
  // Start in IDLE just after an edge; returns in IDLE just after an edge.
  task automatic txn(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit abort);
    int   w;
    ack_t e;
    w = pick(v);
    req = v;
    din = d;
    exp_gnt.push_back(w);
    @(posedge clk); #1;
    chk("busy_in_grant", 32'(busy), 1);
    if (abort) begin
      req = '0;
      din = ~d;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack", 32'(ack), 0);
      chk("abort_A", 32'(A), 32'(ma));
    end else begin
      e.who = w;
      e.data = d[w*W +: W];
      exp_ack.push_back(e);
      ma = e.data;
      mptr = (w + 1) % N;
      @(posedge clk); #1;
      chk("done_busy", 32'(busy), 1);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack", 32'(ack), 0);
      chk("idle_A", 32'(A), 32'(ma));
    end
  endtask
  always @(negedge clk) begin
    if (rstn) begin
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got %b expected none", gnt);
        end else begin
          mon_w = exp_gnt.pop_front();
          chk("gnt", 32'(gnt), 32'(1) << mon_w);
          chk("owner_at_gnt", 32'(owner), 32'(mon_w));
        end
      end
      if (ack) begin
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack=1 expected none");
        end else begin
          mon_e = exp_ack.pop_front();
          chk("ack_A", 32'(A), 32'(mon_e.data));
          chk("ack_owner", 32'(owner), 32'(mon_e.who));
        end
      end
    end
  end
  initial begin
    req = 4'($urandom);
    din = 16'($urandom);
    #1 rstn = 1'b0;
    #1;
    chk("rst_A", 32'(A), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    repeat (2) begin
      @(posedge clk); #1;
      req = 4'($urandom_range(1, 15));
      din = 16'($urandom);
    end
    @(posedge clk); #1;
    chk("rst_hold_gnt", 32'(gnt), 0);
    chk("rst_hold_busy", 32'(busy), 0);
    chk("rst_hold_A", 32'(A), 0);
    req = '0;
    rstn = 1'b1;
    txn(4'b0100, 16'h0A00, 1'b0);
    repeat (5) txn(4'b1111, 16'h4321, 1'b0);
    txn(4'b0001, 16'($urandom), 1'b0);
    txn(4'b1001, 16'($urandom), 1'b0);
    txn(4'b1001, 16'($urandom), 1'b0);
    txn(4'b0001, 16'($urandom), 1'b0);
    txn(4'b0010, 16'($urandom), 1'b1);
    txn(4'b0011, 16'($urandom), 1'b0);
    req = 4'b0100;
    din = 16'h0C00;
    @(posedge clk); #1;
    chk("midrst_gnt_before", 32'(gnt), 32'h4);
    rstn = 1'b0;
    #1;
    chk("midrst_A", 32'(A), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_busy", 32'(busy), 0);
    ma = '0;
    mptr = 0;
    req = '0;
    @(posedge clk); #1;
    chk("midrst_no_ack", 32'(ack), 0);
    rstn = 1'b1;
    txn(4'b0101, 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++)
      txn(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 4) == 0);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
    chk("ack_queue_empty", 32'(exp_ack.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
